// File: rtl/ntsc_sync_decoder.sv
// Recovers horizontal and vertical timing from a 3-bit sampled composite video signal.
// Maps each registered sample into visible-window pixel coordinates and a luminance value.
module ntsc_sync_decoder #(
    parameter logic [9:0] BASE_PIXEL_X          = 10'd184,
    parameter logic [9:0] RESOLUTION_HORIZONTAL = 10'd560,
    parameter logic [9:0] BASE_PIXEL_Y          = 10'd89,
    parameter logic [9:0] RESOLUTION_VERTICAL   = 10'd400
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] ntsc_in,
    output logic       h_sync_out,
    output logic       v_sync_out,
    output logic       field,
    output logic       locked,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       pixel_is_visible,
    output logic [2:0] pixel_data,
    output logic       pixel_valid,
    output logic [1:0] o_dbg_state
);

    localparam logic [1:0] ST_LINE    = 2'd0;
    localparam logic [1:0] ST_VSYNC   = 2'd1;
    localparam logic [1:0] ST_POST_EQ = 2'd2;

    localparam logic [11:0] TIMEOUT_CYCLES = 12'd4000;
    localparam logic [11:0] H_LOAD        = 12'd310;
    localparam logic [10:0] X_END = {1'b0, BASE_PIXEL_X} + {1'b0, RESOLUTION_HORIZONTAL};
    localparam logic [10:0] Y_END = {1'b0, BASE_PIXEL_Y} + {1'b0, RESOLUTION_VERTICAL};

    logic [2:0]  r_ntsc_q;
    logic [10:0] r_run_cnt;
    logic [11:0] r_h_count;
    logic [9:0]  r_line;
    logic [1:0]  r_state;
    logic [3:0]  r_broad_cnt;
    logic [3:0]  r_eq_cnt;
    logic [11:0] r_timeout;
    logic        r_field;
    logic        r_locked;

    logic        w_in_sync;
    logic        w_edge;
    logic        w_is_eq;
    logic        w_is_hsync;
    logic        w_is_broad;
    logic        w_accepted;
    logic        w_timeout_hit;
    logic        w_field_start;
    logic [9:0]  w_hx;
    logic        w_visible;
    logic [2:0]  w_luma;

    // r_run_cnt holds the width of the run that just ended on the first non-sync sample.
    assign w_in_sync     = (r_ntsc_q == 3'd0);
    assign w_edge        = !w_in_sync && (r_run_cnt != 11'd0);
    assign w_is_eq       = w_edge && (r_run_cnt >= 11'd32) && (r_run_cnt <= 11'd175);
    assign w_is_hsync    = w_edge && (r_run_cnt >= 11'd176) && (r_run_cnt <= 11'd699);
    assign w_is_broad    = w_edge && (r_run_cnt >= 11'd700);
    assign w_accepted    = w_is_eq || w_is_hsync || w_is_broad;
    assign w_timeout_hit = !w_accepted && (r_timeout == TIMEOUT_CYCLES - 12'd1);
    assign w_field_start = w_is_hsync && (r_state == ST_POST_EQ) &&
                           ((r_eq_cnt == 4'd7) || (r_eq_cnt == 4'd6));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ntsc_q  <= 3'b001;
            r_run_cnt <= 11'd0;
            r_h_count <= 12'd0;
            r_timeout <= 12'd0;
        end else begin
            r_ntsc_q <= ntsc_in;
            if (!w_in_sync)
                r_run_cnt <= 11'd0;
            else if (r_run_cnt != 11'h7FF)
                r_run_cnt <= r_run_cnt + 11'd1;
            if (w_is_hsync)
                r_h_count <= H_LOAD;
            else if (r_h_count != 12'hFFF)
                r_h_count <= r_h_count + 12'd1;
            if (w_accepted)
                r_timeout <= 12'd0;
            else if (r_timeout != TIMEOUT_CYCLES)
                r_timeout <= r_timeout + 12'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_LINE;
            r_line      <= 10'd0;
            r_broad_cnt <= 4'd0;
            r_eq_cnt    <= 4'd0;
            r_field     <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            if (w_timeout_hit)
                r_locked <= 1'b0;
            // A broad pulse restarts vertical sync from any state.
            if (w_is_broad) begin
                r_state <= ST_VSYNC;
                if (r_state != ST_VSYNC)
                    r_broad_cnt <= 4'd1;
                else if (r_broad_cnt != 4'hF)
                    r_broad_cnt <= r_broad_cnt + 4'd1;
            end else begin
                case (r_state)
                    ST_VSYNC: begin
                        if (w_is_eq) begin
                            if (r_broad_cnt >= 4'd6) begin
                                r_state  <= ST_POST_EQ;
                                r_eq_cnt <= 4'd1;
                            end else begin
                                r_state  <= ST_LINE;
                                r_locked <= 1'b0;
                            end
                        end else if (w_is_hsync) begin
                            r_state  <= ST_LINE;
                            r_locked <= 1'b0;
                        end
                    end
                    ST_POST_EQ: begin
                        if (w_is_eq) begin
                            if (r_eq_cnt != 4'hF)
                                r_eq_cnt <= r_eq_cnt + 4'd1;
                        end else if (w_is_hsync) begin
                            r_state <= ST_LINE;
                            if (r_eq_cnt == 4'd7) begin
                                r_line   <= 10'd20;
                                r_field  <= 1'b0;
                                r_locked <= 1'b1;
                            end else if (r_eq_cnt == 4'd6) begin
                                r_line   <= 10'd19;
                                r_field  <= 1'b1;
                                r_locked <= 1'b1;
                            end else begin
                                r_locked <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        if (w_is_hsync)
                            r_line <= (r_line >= 10'd1021) ? 10'd1023 : r_line + 10'd2;
                    end
                endcase
            end
        end
    end

    assign w_hx      = r_h_count[11:2];
    assign w_visible = (w_hx >= BASE_PIXEL_X) && ({1'b0, w_hx} < X_END) &&
                       (r_line >= BASE_PIXEL_Y) && ({1'b0, r_line} < Y_END);
    // Sync, blank and black all decode to luminance 0.
    assign w_luma    = (r_ntsc_q >= 3'd3) ? (r_ntsc_q - 3'd2) : 3'd0;

    assign h_sync_out       = w_is_hsync;
    assign v_sync_out       = w_field_start;
    assign field            = r_field;
    assign locked           = r_locked;
    assign pixel_is_visible = w_visible;
    assign pixel_x          = w_visible ? (w_hx - BASE_PIXEL_X) : 10'd0;
    assign pixel_y          = w_visible ? (r_line - BASE_PIXEL_Y) : 10'd0;
    assign pixel_data       = w_visible ? w_luma : 3'd0;
    assign pixel_valid      = w_visible && r_locked;
    assign o_dbg_state      = r_state;

endmodule

// File: doc/ntsc_sync_decoder.md
NTSC_SYNC_DECODER -- requirements
Module: ntsc_sync_decoder

Interface
REQ-001 SHALL have parameter BASE_PIXEL_X, default 10'd184: first visible pixel column, in units of h_count[11:2].
REQ-002 SHALL have parameter RESOLUTION_HORIZONTAL, default 10'd560: number of visible columns.
REQ-003 SHALL have parameter BASE_PIXEL_Y, default 10'd89: first visible line number.
REQ-004 SHALL have parameter RESOLUTION_VERTICAL, default 10'd400: number of visible lines.
REQ-005 SHALL have port clk, input, 1 bit: the single 50 MHz clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port ntsc_in, input, 3 bits: sampled composite level (000 sync, 001 blank, 010 black … 111 bright white).
REQ-008 SHALL have port h_sync_out, output, 1 bit: one-cycle pulse on each accepted h-sync trailing edge.
REQ-009 SHALL have port v_sync_out, output, 1 bit: one-cycle pulse when the line counter is loaded at field start.
REQ-010 SHALL have port field, output, 1 bit: 0 = even field (lines 20,22,…), 1 = odd field (lines 19,21,…).
REQ-011 SHALL have port locked, output, 1 bit: timing recovered and valid.
REQ-012 SHALL have ports pixel_x, pixel_y, output, 10 bits each: visible-area coordinates, 0 when not visible.
REQ-013 SHALL have port pixel_is_visible, output, 1 bit: current sample lies in the visible window.
REQ-014 SHALL have port pixel_data, output, 3 bits: decoded luminance 0..5.
REQ-015 SHALL have port pixel_valid, output, 1 bit: pixel_is_visible AND locked.

Function
REQ-016 SHALL register ntsc_in once (ntsc_q); all outputs SHALL be aligned with ntsc_q, one cycle after input.
REQ-017 SHALL measure every run of consecutive ntsc_q == 000 with an 11-bit saturating counter and classify the run on its trailing edge (first non-000 sample).
REQ-018 SHALL classify a run as follows: width below 32 = glitch, ignored; width 32–175 = EQ; width 176–699 = HSYNC; width 700 or more = BROAD.
REQ-019 SHALL keep a 12-bit h_count that increments each cycle, saturates at 4095, and loads 310 on the trailing-edge cycle of an HSYNC run.
REQ-020 SHALL keep the state machine in one of three states: LINE, VSYNC or POST_EQ.
REQ-021 SHALL, from any state, on a BROAD run go to VSYNC with broad_cnt incremented; broad_cnt SHALL be cleared on entry from another state.
REQ-022 SHALL, in VSYNC, on an EQ run go to POST_EQ with eq_cnt=1 when broad_cnt ≥ 6; otherwise it SHALL clear locked and go to LINE.
REQ-023 SHALL, in VSYNC, on an HSYNC run clear locked and go to LINE.
REQ-024 SHALL, in POST_EQ, increment eq_cnt (saturating at 15) on each EQ run.
REQ-025 SHALL, in POST_EQ, on an HSYNC run with eq_cnt == 7 load line=20, set field=0, set locked=1, pulse v_sync_out and go to LINE.
REQ-026 SHALL, in POST_EQ, on an HSYNC run with eq_cnt == 6 do the same with line=19 and field=1.
REQ-027 SHALL, in POST_EQ, on an HSYNC run with any other eq_cnt clear locked and go to LINE without loading line.
REQ-028 SHALL, in LINE, on each HSYNC run increment line by 2, saturating at 1023; EQ runs in LINE SHALL be ignored.
REQ-029 SHALL pulse h_sync_out on every HSYNC trailing edge in every state, including the field-start edge.
REQ-030 SHALL clear locked when 4000 consecutive cycles pass without an accepted (non-glitch) sync run.
REQ-031 SHALL drive pixel_is_visible = h_count[11:2] in [BASE_PIXEL_X, BASE_PIXEL_X+RESOLUTION_HORIZONTAL) AND line in [BASE_PIXEL_Y, BASE_PIXEL_Y+RESOLUTION_VERTICAL).
REQ-032 SHALL drive pixel_x = h_count[11:2]−BASE_PIXEL_X and pixel_y = line−BASE_PIXEL_Y when visible, else 0.
REQ-033 SHALL decode pixel_data from ntsc_q: 001→0, 010→0, 011→1, 100→2, 101→3, 110→4, 111→5, 000→0.
REQ-034 SHALL force pixel_data to 0 when pixel_is_visible is 0.

Reset
REQ-035 SHALL, while reset is high, set ntsc_q=001, state=LINE, h_count, line, run counter, broad_cnt, eq_cnt and the timeout counter to 0, and field, locked and all pulse outputs to 0.
REQ-036 SHALL treat reset asserted mid-run or mid-vertical-interval as abandoning that run or interval; no pulse SHALL be emitted for it after release.

Verification
REQ-037 SHALL be verified with a full even-field vertical sequence (6 EQ, 6 BROAD of 1353, 7 EQ of 117, then HSYNC of 234): v_sync_out pulses once, field=0, locked=1, line=20.
REQ-038 SHALL be verified with the odd-field sequence (6 post-VB EQ): field=1, line=19; each following HSYNC adds 2.
REQ-039 SHALL be verified with, after lock, line 109 and sample 001 at h_count=940: pixel_x=51, pixel_y=20, pixel_valid=1; input 111 there gives pixel_data=5.
REQ-040 SHALL be verified with sync runs of 31, 175, 176, 699 and 700 cycles: classified as glitch, EQ, HSYNC, HSYNC and BROAD respectively.
REQ-041 SHALL be verified with input held at 001 for 4000 cycles after lock: locked drops to 0 and pixel_valid goes to 0.
REQ-042 SHALL be verified with only 5 BROAD runs followed by EQ: no v_sync_out, locked=0, state=LINE.
